// File: rtl/ysyx_210247_if_axi_rd_if.sv
// ysyx_210247_if_axi_rd_if: IF-stage fetch handshake plus single-beat AXI4 read channels
interface ysyx_210247_if_axi_rd_if #(
    parameter int ADDR_W = 32
);
    logic              inst_valid;
    logic [63:0]       inst_addr;
    logic [1:0]        inst_size;
    logic              inst_ready;
    logic [63:0]       inst_read;
    logic [1:0]        inst_resp;
    logic              ar_valid;
    logic              ar_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic [3:0]        ar_id;
    logic [7:0]        ar_len;
    logic [2:0]        ar_size;
    logic [1:0]        ar_burst;
    logic              r_valid;
    logic              r_ready;
    logic [63:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_last;
    logic [3:0]        r_id;

    modport master (
        input  inst_valid, inst_addr, inst_size, ar_ready, r_valid, r_data, r_resp, r_last, r_id,
        output inst_ready, inst_read, inst_resp, ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
    );

    modport slave (
        output inst_valid, inst_addr, inst_size, ar_ready, r_valid, r_data, r_resp, r_last, r_id,
        input  inst_ready, inst_read, inst_resp, ar_valid, ar_addr, ar_id, ar_len, ar_size, ar_burst, r_ready
    );
endinterface

// File: rtl/ysyx_210247_if_axi_rd.sv
// ysyx_210247_if_axi_rd: turns IF-stage fetch requests into single-beat AXI4 reads and buffers the word
module ysyx_210247_if_axi_rd #(
    parameter logic [3:0] AXI_ID = 4'd0,
    parameter int         ADDR_W = 32
) (
    input logic clk,
    input logic rst,
    ysyx_210247_if_axi_rd_if.master bus
);
    typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

    state_t      state, state_next;
    logic [63:0] req_addr, buf_data;
    logic [1:0]  buf_resp;
    logic        ar_valid_q, r_ready_q;
    logic        ld_req, ld_err, ld_r, inst_ready;
    logic        aligned, match;
    logic        unused_ok;

    assign aligned = bus.inst_addr[1:0] == 2'b00;
    assign match   = bus.inst_addr == req_addr;

    assign bus.inst_ready = inst_ready;
    assign bus.inst_read  = buf_data;
    assign bus.inst_resp  = buf_resp;
    assign bus.ar_valid   = ar_valid_q;
    assign bus.ar_addr    = req_addr[ADDR_W-1:0];
    assign bus.ar_id      = AXI_ID;
    assign bus.ar_len     = 8'd0;
    assign bus.ar_size    = 3'b010;
    assign bus.ar_burst   = 2'b01;
    assign bus.r_ready    = r_ready_q;
    assign unused_ok      = &{1'b0, bus.inst_size, bus.r_last, bus.r_id};

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // AXI valid/ready flags follow the next state; request address and response buffer load on enables
    always_ff @(posedge clk) begin
        if (rst) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            req_addr   <= 64'd0;
            buf_data   <= 64'd0;
            buf_resp   <= 2'b00;
        end else begin
            ar_valid_q <= state_next == ADDR;
            r_ready_q  <= state_next == DATA;
            if (ld_req) req_addr <= bus.inst_addr;
            if (ld_err) begin
                buf_data <= 64'd0;
                buf_resp <= 2'b10;
            end
            if (ld_r) begin
                buf_data <= req_addr[2] ? {32'd0, bus.r_data[63:32]} : {32'd0, bus.r_data[31:0]};
                buf_resp <= bus.r_resp;
            end
        end
    end

    // next state, buffer load enables and the combinational handshake; stale words are dropped only in HOLD
    always_comb begin
        state_next = state;
        inst_ready = 1'b0;
        ld_req     = 1'b0;
        ld_err     = 1'b0;
        ld_r       = 1'b0;
        case (state)
            IDLE: begin
                ld_req     = bus.inst_valid;
                ld_err     = bus.inst_valid & ~aligned;
                state_next = ~bus.inst_valid ? IDLE : aligned ? ADDR : HOLD;
            end
            ADDR: state_next = bus.ar_ready ? DATA : ADDR;
            DATA: begin
                ld_r       = bus.r_valid;
                state_next = bus.r_valid ? HOLD : DATA;
            end
            HOLD: begin
                inst_ready = bus.inst_valid & match;
                ld_req     = bus.inst_valid & ~match;
                ld_err     = bus.inst_valid & ~match & ~aligned;
                state_next = ~bus.inst_valid ? HOLD : match ? IDLE : aligned ? ADDR : HOLD;
            end
        endcase
    end
endmodule
